pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the five-stage RV32 pipeline; complements the existing forwarding-only hazard unit. Detects load-use hazards and control-flow redirects, freezes the pipeline while a multi-cycle data-memory access is outstanding, and clears the non-reset pipeline registers after reset. Drives the stall/flush enables of the PC and the four inter-stage registers, and keeps saturating performance counters.

## Interface
- `LOAD_RESULTSRC`, default 2'b01 — `ResultSrcE` encoding that marks a load.
- `INIT_CYCLES`, default 4 — post-reset flush length in cycles (≥1).
- `MEM_TIMEOUT`, default 255 — maximum MEM_WAIT cycles before forced release.
- `CNT_W`, default 32 — performance counter width.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset; one clock, synchronous, active-high.
- `Rs1D`, `Rs2D` in 5 — source registers of the instruction in Decode.
- `RdE` in 5 — destination of the instruction in Execute.
- `RegWriteE` in 1 — Execute instruction writes a register.
- `ResultSrcE` in 2 — Execute result select.
- `PCSrcE` in 2 — nonzero means redirect (branch taken or jump).
- `MemReqM` in 1 — Memory-stage instruction is accessing data memory.
- `MemReadyM` in 1 — data memory completes the access this cycle.
- `StallF` out 1 — hold the PC.
- `StallD` out 1 — hold fetch_to_decode.
- `StallE` out 1 — hold decode_to_execute.
- `StallM` out 1 — hold execute_to_memory.
- `FlushD` out 1 — clear fetch_to_decode.
- `FlushE` out 1 — clear decode_to_execute.
- `FlushM` out 1 — clear execute_to_memory.
- `FlushW` out 1 — clear memory_to_writeback.
- `State` out 2 — 0 INIT, 1 RUN, 2 MEM_WAIT.
- `MemErr` out 1 — sticky; a MEM_TIMEOUT expiry occurred.
- `LoadUseCount` out CNT_W — load-use stall cycles.
- `RedirectCount` out CNT_W — redirect flush events.
- `MemWaitCount` out CNT_W — MEM_WAIT cycles.

## Operation
- In every register, flush overrides stall.
- Load-use (`lu`) is `RegWriteE & (ResultSrcE==LOAD_RESULTSRC) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D)`.
- Redirect (`rd`) is `PCSrcE!=0`.
- Memory stall (`ms`) is `MemReqM & ~MemReadyM`.

States:
- INIT
  - Outputs: StallF=1; FlushD, FlushE, FlushM, FlushW =1; all other outputs 0.
  - An internal counter runs 0..INIT_CYCLES-1, then the state moves to RUN.
  - No counters update.
- RUN, priority ms > rd > lu:
  - ms: StallF, StallD, StallE, StallM, FlushW =1. Next state MEM_WAIT.
  - rd: FlushD, FlushE =1. Increment RedirectCount. A simultaneous `lu` is ignored because that Decode instruction is on the wrong path.
  - lu: StallF, StallD, FlushE =1. Increment LoadUseCount.
  - Otherwise all outputs 0.
- MEM_WAIT:
  - While `~MemReadyM`, drive the same outputs as ms. Increment MemWaitCount and a wait counter.
  - When `MemReadyM`=1, all stalls drop in that same cycle and the state moves to RUN. A pending rd/lu in that cycle is evaluated as in RUN.
  - When the wait counter reaches MEM_TIMEOUT, set MemErr, release the stalls for that cycle, and return to RUN. The wait counter clears on every exit.
- While frozen by ms, `PCSrcE` and `lu` are ignored, since E and D are held and are re-evaluated after release.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Control outputs are combinational from the state plus current inputs. There are no glitch requirements beyond single-clock timing.

## Timing
- While `rst`=1: State=INIT, init counter=0, wait counter=0, all perf counters=0, MemErr=0.
- Outputs show the INIT pattern during reset and for INIT_CYCLES cycles after `rst` falls.
- The first RUN cycle is INIT_CYCLES+1 edges after `rst` deasserts.
- A reset asserted mid-MEM_WAIT or mid-INIT returns to INIT on the next edge and discards counts.
- Latency is zero:
  - A hazard condition and its stall/flush appear in the same cycle.
  - A load-use stall lasts exactly one cycle, because the load advances to M.
- A MEM_WAIT of N not-ready cycles stalls for N cycles and releases in the cycle `MemReadyM` rises. `MemReadyM` coincident with `MemReqM` in RUN causes no stall.

## Test plan
- Reset sequence: rst high for 2 cycles, then low with INIT_CYCLES=4 → FlushD/E/M/W=1 and StallF=1 for 4 cycles after rst falls, State=1 on the 5th, all counters 0.
- Load-use: ResultSrcE=01, RegWriteE=1, RdE=5, Rs2D=5 → one cycle of StallF=StallD=FlushE=1, LoadUseCount=1. Repeat with RdE=0 → no stall.
- Redirect with load-use: PCSrcE=01 together with the load-use above → FlushD=FlushE=1, StallF=0, RedirectCount=1, LoadUseCount unchanged.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles then high → StallF/D/E/M=1 and FlushW=1 for 3 cycles, State=2 for 2 of them, release on cycle 4, MemWaitCount=3.
- Timeout: MEM_TIMEOUT=8, MemReadyM held low → MemErr=1 at the 8th wait cycle, State returns to 1, stalls drop, MemErr stays 1 until rst.
- Saturation: CNT_W=4 with 20 load-use events → LoadUseCount holds at 15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the five-stage RV32 pipeline.
// Detects load-use hazards and redirects, freezes the pipeline during
// multi-cycle data-memory accesses, flushes the pipe after reset and
// keeps saturating performance counters.
module pipeline_stall_controller #(
    parameter logic [1:0]  LOAD_RESULTSRC = 2'b01,
    parameter int unsigned INIT_CYCLES    = 4,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       State,
    output logic             MemErr,
    output logic [CNT_W-1:0] LoadUseCount,
    output logic [CNT_W-1:0] RedirectCount,
    output logic [CNT_W-1:0] MemWaitCount
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [INIT_W-1:0] initCnt;
    logic [WAIT_W-1:0] waitCnt;

    logic loadUse;
    logic redirect;
    logic memStall;
    logic initOut;
    logic memOut;
    logic evalHazard;
    logic incLoadUse;
    logic incRedirect;
    logic incMemWait;
    logic timeoutHit;

    assign State = state;

    // Raw hazard conditions from the current pipeline contents
    always_comb begin
        loadUse  = RegWriteE && (ResultSrcE == LOAD_RESULTSRC) && (RdE != 5'd0)
                   && ((RdE == Rs1D) || (RdE == Rs2D));
        redirect = (PCSrcE != 2'b00);
        memStall = MemReqM && !MemReadyM;
    end

    // Next-state and stall/flush decode; release cycles re-evaluate rd/lu
    always_comb begin
        stateNext   = state;
        initOut     = 1'b0;
        memOut      = 1'b0;
        evalHazard  = 1'b0;
        incLoadUse  = 1'b0;
        incRedirect = 1'b0;
        incMemWait  = 1'b0;
        timeoutHit  = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;

        if (rst) begin
            initOut   = 1'b1;
            stateNext = ST_INIT;
        end else begin
            case (state)
                ST_INIT: begin
                    initOut = 1'b1;
                    if (initCnt == INIT_W'(INIT_CYCLES - 1)) begin
                        stateNext = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (memStall) begin
                        memOut     = 1'b1;
                        incMemWait = 1'b1;
                        stateNext  = ST_MEM_WAIT;
                    end else begin
                        evalHazard = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // waitCnt holds the stalled cycles already spent on this access
                    if (!MemReadyM && (waitCnt != WAIT_W'(MEM_TIMEOUT))) begin
                        memOut     = 1'b1;
                        incMemWait = 1'b1;
                    end else begin
                        timeoutHit = !MemReadyM;
                        evalHazard = 1'b1;
                        stateNext  = ST_RUN;
                    end
                end
                default: begin
                    initOut   = 1'b1;
                    stateNext = ST_INIT;
                end
            endcase

            if (evalHazard) begin
                if (redirect) begin
                    FlushD      = 1'b1;
                    FlushE      = 1'b1;
                    incRedirect = 1'b1;
                end else if (loadUse) begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    FlushE     = 1'b1;
                    incLoadUse = 1'b1;
                end
            end
        end

        if (initOut) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end
        if (memOut) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end
    end

    // State register with init/wait sequencing counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            initCnt <= '0;
            waitCnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            initCnt <= ((state == ST_INIT) && (stateNext == ST_INIT)) ? initCnt + INIT_W'(1) : '0;
            waitCnt <= incMemWait ? waitCnt + WAIT_W'(1) : '0;
            MemErr  <= MemErr | timeoutHit;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            LoadUseCount  <= '0;
            RedirectCount <= '0;
            MemWaitCount  <= '0;
        end else begin
            if (incLoadUse && (LoadUseCount != CNT_MAX)) begin
                LoadUseCount <= LoadUseCount + CNT_W'(1);
            end
            if (incRedirect && (RedirectCount != CNT_MAX)) begin
                RedirectCount <= RedirectCount + CNT_W'(1);
            end
            if (incMemWait && (MemWaitCount != CNT_MAX)) begin
                MemWaitCount <= MemWaitCount + CNT_W'(1);
            end
        end
    end

endmodule
